// File: rtl/edge_setup_pkg.sv
// Shared constants and FSM state type for the triangle edge-setup stage.
package edge_setup_pkg;

    localparam int unsigned H_LAST     = 799;
    localparam int unsigned V_LAST     = 524;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned COORD_W    = 20;
    localparam int unsigned MUL_CYCLES = 20;
    localparam int unsigned PROD_W     = 2 * COORD_W;
    localparam int unsigned NUM_PROD   = 6;

    typedef enum logic [1:0] {
        StIdle,
        StLatch,
        StMul,
        StReady
    } state_e;

endpackage

// File: rtl/seq_mul_s20.sv
// Sequential signed 20x20 multiplier: sign-magnitude shift-add, one partial product per cycle.
module seq_mul_s20
    import edge_setup_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic signed [COORD_W-1:0] a_i,
    input  logic signed [COORD_W-1:0] b_i,
    output logic                      done_o,
    output logic signed [PROD_W-1:0]  p_o
);

    logic [PROD_W-1:0]  mcand_q, mcand_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [COORD_W-1:0] mplier_q, mplier_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic [COORD_W-1:0] a_mag, b_mag;

    // Magnitude of -2^19 is 2^19, which still fits an unsigned 20-bit value.
    assign a_mag = a_i[COORD_W-1] ? $unsigned(-a_i) : $unsigned(a_i);
    assign b_mag = b_i[COORD_W-1] ? $unsigned(-b_i) : $unsigned(b_i);

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        if (start_i) begin
            mcand_d  = {{COORD_W{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            neg_d    = a_i[COORD_W-1] ^ b_i[COORD_W-1];
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign done_o = done_q;
    assign p_o    = neg_q ? -$signed(acc_q) : $signed(acc_q);

endmodule

// File: rtl/edge_setup.sv
// Per-frame triangle edge setup: latches vertices, computes line-0 edge values, steps per line.
module edge_setup
    import edge_setup_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic signed [COORD_W-1:0] x_screen_v0,
    input  logic signed [COORD_W-1:0] x_screen_v1,
    input  logic signed [COORD_W-1:0] x_screen_v2,
    input  logic signed [COORD_W-1:0] y_screen_v0,
    input  logic signed [COORD_W-1:0] y_screen_v1,
    input  logic signed [COORD_W-1:0] y_screen_v2,
    output logic signed [COORD_W-1:0] y_screen_v0_o,
    output logic signed [COORD_W-1:0] y_screen_v1_o,
    output logic signed [COORD_W-1:0] y_screen_v2_o,
    output logic signed [COORD_W-1:0] e0_init_t1,
    output logic signed [COORD_W-1:0] e1_init_t1,
    output logic signed [COORD_W-1:0] e2_init_t1,
    output logic                      setup_done
);

    localparam logic [9:0] XLast   = 10'(H_LAST);
    localparam logic [9:0] YLast   = 10'(V_LAST);
    localparam logic [9:0] YActive = 10'(V_ACTIVE);

    typedef logic signed [COORD_W-1:0] coord_t;

    state_e                   state_q, state_d;
    coord_t                   xv_q[3], xv_d[3], yv_q[3], yv_d[3];
    coord_t                   a_q[3], a_d[3], b_q[3], b_d[3];
    coord_t                   e_q[3], e_d[3], pend_q[3], pend_d[3];
    logic signed [PROD_W-1:0] acc_q, acc_d, diff, mul_p;
    logic [2:0]               idx_q, idx_d, sel;
    logic [1:0]               k_sel, k_cur;
    logic                     first_q, first_d, done_q, done_d;
    logic                     trigger, line_step, mul_start, mul_done;
    coord_t                   op_a, op_b;

    assign trigger   = (state_q == StIdle || state_q == StReady) && y == YActive && x == 10'd0;
    assign line_step = (state_q == StReady) && x == XLast && (y < YActive || y == YLast);

    // Product order per edge k: y_k*b_k (even index) then x_k*a_k (odd index).
    assign sel   = first_q ? 3'd0 : 3'(idx_q + 3'd1);
    assign k_sel = sel[2:1];
    assign k_cur = idx_q[2:1];
    assign op_a  = sel[0] ? xv_q[k_sel] : yv_q[k_sel];
    assign op_b  = sel[0] ? a_q[k_sel] : b_q[k_sel];
    assign diff  = acc_q - mul_p;

    always_comb begin
        state_d   = state_q;
        xv_d      = xv_q;
        yv_d      = yv_q;
        a_d       = a_q;
        b_d       = b_q;
        e_d       = e_q;
        pend_d    = pend_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        first_d   = 1'b0;
        done_d    = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger) state_d = StLatch;
            end
            StLatch: begin
                xv_d    = '{x_screen_v0, x_screen_v1, x_screen_v2};
                yv_d    = '{y_screen_v0, y_screen_v1, y_screen_v2};
                a_d     = '{y_screen_v1 - y_screen_v0, y_screen_v2 - y_screen_v1,
                            y_screen_v0 - y_screen_v2};
                b_d     = '{x_screen_v1 - x_screen_v0, x_screen_v2 - x_screen_v1,
                            x_screen_v0 - x_screen_v2};
                idx_d   = '0;
                first_d = 1'b1;
                state_d = StMul;
            end
            StMul: begin
                mul_start = first_q || (mul_done && idx_q != 3'(NUM_PROD - 1));
                if (mul_done) begin
                    if (!idx_q[0]) begin
                        acc_d = mul_p;
                    end else begin
                        pend_d[k_cur] = diff[COORD_W-1:0];
                    end
                    if (idx_q == 3'(NUM_PROD - 1)) begin
                        e_d     = '{pend_q[0], pend_q[1], diff[COORD_W-1:0]};
                        done_d  = 1'b1;
                        state_d = StReady;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StReady: begin
                if (trigger) begin
                    state_d = StLatch;
                end else if (line_step) begin
                    for (int k = 0; k < 3; k++) e_d[k] = e_q[k] - b_q[k];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            for (int k = 0; k < 3; k++) begin
                xv_q[k]   <= '0;
                yv_q[k]   <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                e_q[k]    <= '0;
                pend_q[k] <= '0;
            end
            acc_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xv_q    <= xv_d;
            yv_q    <= yv_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    seq_mul_s20 u_mul (
        .clk     (clk),
        .reset   (reset),
        .start_i (mul_start),
        .a_i     (op_a),
        .b_i     (op_b),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );

    assign y_screen_v0_o = yv_q[0];
    assign y_screen_v1_o = yv_q[1];
    assign y_screen_v2_o = yv_q[2];
    assign e0_init_t1    = e_q[0];
    assign e1_init_t1    = e_q[1];
    assign e2_init_t1    = e_q[2];
    assign setup_done    = done_q;

endmodule

// File: tb/tb_edge_setup.sv
// Self-checking bench for edge_setup: directed frames plus randomized frames vs. an arithmetic model.
module tb_edge_setup;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [9:0]         x = '0, y = '0;
    logic signed [19:0] xs0 = '0, xs1 = '0, xs2 = '0, ys0 = '0, ys1 = '0, ys2 = '0;
    logic signed [19:0] yo0, yo1, yo2, e0, e1, e2;
    logic               setup_done;

    int n_cmp = 0;
    int n_err = 0;

    // Bench-side stimulus vertices and reference model state.
    int                 vx[3], vy[3];
    int                 m_a[3], m_b[3];
    logic signed [19:0] m_e[3];
    int                 m_y[3];

    edge_setup dut (
        .clk           (clk),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .x_screen_v0   (xs0),
        .x_screen_v1   (xs1),
        .x_screen_v2   (xs2),
        .y_screen_v0   (ys0),
        .y_screen_v1   (ys1),
        .y_screen_v2   (ys2),
        .y_screen_v0_o (yo0),
        .y_screen_v1_o (yo1),
        .y_screen_v2_o (yo2),
        .e0_init_t1    (e0),
        .e1_init_t1    (e1),
        .e2_init_t1    (e2),
        .setup_done    (setup_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [19:0] wrap20(input longint v);
        logic [63:0] t;
        t = v;
        return t[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_xy(input int xx, input int yy);
        x = 10'(xx);
        y = 10'(yy);
    endtask

    task automatic apply_vtx();
        xs0 = 20'(vx[0]); xs1 = 20'(vx[1]); xs2 = 20'(vx[2]);
        ys0 = 20'(vy[0]); ys1 = 20'(vy[1]); ys2 = 20'(vy[2]);
    endtask

    task automatic rand_vtx();
        for (int k = 0; k < 3; k++) begin
            vx[k] = int'($urandom_range(1600)) - 800;
            vy[k] = int'($urandom_range(1600)) - 800;
        end
    endtask

    task automatic check_e(input string tag);
        check_eq({tag, "_e0"}, e0, m_e[0]);
        check_eq({tag, "_e1"}, e1, m_e[1]);
        check_eq({tag, "_e2"}, e2, m_e[2]);
    endtask

    task automatic check_y(input string tag);
        check_eq({tag, "_y0"}, yo0, m_y[0]);
        check_eq({tag, "_y1"}, yo1, m_y[1]);
        check_eq({tag, "_y2"}, yo2, m_y[2]);
    endtask

    // Trigger a frame, latch the current vertices, wait for completion.
    task automatic run_frame(input string tag, input bit inject);
        int got;
        int lx[3], ly[3];
        apply_vtx();
        set_xy(0, 480);
        tick();
        set_xy(0, 481);
        tick();
        for (int k = 0; k < 3; k++) begin
            lx[k]  = vx[k];
            ly[k]  = vy[k];
            m_y[k] = vy[k];
        end
        check_y({tag, "_latch"});
        got = 0;
        for (int c = 0; c < 300 && got == 0; c++) begin
            if (inject) begin
                rand_vtx();
                apply_vtx();
                case ($urandom_range(3))
                    0: set_xy(799, 524);
                    1: set_xy(799, int'($urandom_range(479)));
                    default: set_xy(int'($urandom_range(798)), 481);
                endcase
            end
            tick();
            if (setup_done) got = 1;
            else check_e({tag, "_hold"});
        end
        set_xy(5, 481);
        check_eq({tag, "_done"}, got, 1);
        for (int k = 0; k < 3; k++) begin
            m_a[k] = ly[(k + 1) % 3] - ly[k];
            m_b[k] = lx[(k + 1) % 3] - lx[k];
            m_e[k] = wrap20(longint'(ly[k]) * m_b[k] - longint'(lx[k]) * m_a[k]);
        end
        check_e(tag);
        check_y({tag, "_post"});
        tick();
        check_eq({tag, "_pulse"}, setup_done, 0);
        check_e({tag, "_post"});
    endtask

    task automatic line_step(input string tag, input int yy);
        set_xy(799, yy);
        tick();
        set_xy(5, yy);
        for (int k = 0; k < 3; k++) m_e[k] = wrap20(longint'(m_e[k]) - m_b[k]);
        check_e(tag);
    endtask

    task automatic set_v1();
        vx = '{100, 200, 300};
        vy = '{100, 300, 100};
    endtask

    initial begin
        int pulses;
        for (int k = 0; k < 3; k++) begin
            m_e[k] = '0; m_y[k] = 0; m_a[k] = 0; m_b[k] = 0;
        end
        set_xy(5, 481);
        tick();
        tick();
        check_e("rst");
        check_y("rst");
        check_eq("rst_done", setup_done, 0);
        reset = 1'b0;
        tick();
        check_e("idle");
        check_eq("idle_done", setup_done, 0);

        // Reference triangle
        set_v1();
        run_frame("v1", 1'b0);
        check_eq("v1_e0_const", e0, -10000);
        check_eq("v1_e1_const", e1, 70000);
        check_eq("v1_e2_const", e2, -20000);
        check_eq("v1_y1_const", yo1, 300);

        line_step("v2_524", 524);
        check_eq("v2_a_const", e1, 69900);
        line_step("v2_0", 0);
        check_eq("v2_b_const", e2, -19600);

        for (int yy = 1; yy <= 148; yy++) line_step("v3_step", yy);
        check_eq("v3_e0", longint'(e0) + 200 * 200, 15000);
        check_eq("v3_e1", longint'(e1) + 200 * (-200), 15000);
        check_eq("v3_e2", longint'(e2) + 200 * 0, 10000);

        // Vertex churn and line-step pulses while multiplying
        set_v1();
        run_frame("v4", 1'b1);
        check_eq("v4_e0_const", e0, -10000);
        check_eq("v4_e1_const", e1, 70000);
        check_eq("v4_e2_const", e2, -20000);

        // Reset mid-multiply
        set_v1();
        apply_vtx();
        set_xy(0, 480);
        tick();
        set_xy(0, 481);
        tick();
        for (int c = 0; c < 50; c++) tick();
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            m_e[k] = '0; m_y[k] = 0;
        end
        check_e("v5_async");
        check_y("v5_async");
        check_eq("v5_async_done", setup_done, 0);
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (setup_done) pulses++;
        end
        check_eq("v5_no_done", pulses, 0);
        check_e("v5_idle");
        set_v1();
        run_frame("v5_rerun", 1'b0);
        check_eq("v5_e1_const", e1, 70000);

        // Wrap of an oversized init value
        vx = '{0, 1000, -1000};
        vy = '{0, 500, 500};
        run_frame("v6", 1'b0);
        check_eq("v6_e1_wrap", e1, 48576);

        for (int f = 0; f < 6; f++) begin
            rand_vtx();
            run_frame("rnd", 1'($urandom_range(1)));
            line_step("rnd_524", 524);
            for (int yy = 0; yy < int'($urandom_range(20)); yy++) line_step("rnd_step", yy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
